mips_ifetch: RTL

MIPS_IFETCH -- requirements
Module: mips_ifetch

---
 rtl/mips_ifetch.sv | 112 +++++++++++
 1 files changed

// File: rtl/mips_ifetch.sv
// MIPS instruction fetch/issue stage: a two-state fetch/issue loop that owns
// the PC, the instruction register and the retired-instruction counter.
module mips_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic        instr_valid,
  output logic [31:0] ir,
  output logic [5:0]  op,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retire_cnt
);

  localparam int unsigned WORD_W = 30;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  pc_word_q;
  logic [WORD_W-1:0]  pc4_word;
  logic [WORD_W-1:0]  next_word;
  logic [31:0]        ir_q;
  logic [31:0]        retire_q;
  logic               first_q;
  logic               ack_prev_q;
  logic               load_ir;
  logic               advance;

  // PC is held as a word address so the two low bits are zero by construction.
  assign pc4_word = pc_word_q + WORD_W'(1);

  // Jump wins over branch; branch offset is a sign-extended word offset.
  always_comb begin
    next_word = pc4_word;
    if (jump) begin
      next_word = {pc4_word[WORD_W-1:26], ir_q[25:0]};
    end else if (branch && zero) begin
      next_word = pc4_word + {{14{ir_q[15]}}, ir_q[15:0]};
    end
  end

  // Next-state logic; an ack already high through reset is not taken on the
  // first post-reset fetch cycle.
  always_comb begin
    state_d = state_q;
    load_ir = 1'b0;
    advance = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_ack && !(first_q && ack_prev_q)) begin
          load_ir = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          advance = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_word_q <= RESET_PC[31:2];
      ir_q      <= '0;
      retire_q  <= '0;
      first_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      first_q <= 1'b0;
      if (load_ir) begin
        ir_q <= imem_rdata;
      end
      if (advance) begin
        pc_word_q <= next_word;
        retire_q  <= retire_q + 32'd1;
      end
    end
  end

  // Ack history, kept running through reset so the level seen during reset is known.
  always_ff @(posedge clk) begin
    ack_prev_q <= imem_ack;
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = {pc_word_q, 2'b00};
  assign instr_valid = (state_q == ISSUE);
  assign ir          = ir_q;
  assign op          = ir_q[31:26];
  assign pc          = {pc_word_q, 2'b00};
  assign pc_plus4    = {pc4_word, 2'b00};
  assign retire_cnt  = retire_q;

endmodule
